mem_dump_reader: RTL and testbench

//  Initiator side of the data-memory port. On a start pulse, reads a block of

---
 rtl/mem_dump_reader_pkg.sv | 19 +
 rtl/mem_dump_reader_word_byte_serializer.sv | 53 +++++
 rtl/mem_dump_reader.sv | 116 +++++++++++
 tb/tb_mem_dump_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory dump reader: FSM state encodings and byte width,
// also used by the debug unit.
package mem_dump_reader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_dump_reader_word_byte_serializer.sv
// Holds one memory word and presents it LSB byte first on a valid/ready stream.
// tx_valid is purely registered, so it never depends combinationally on ready.
module mem_dump_reader_word_byte_serializer
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [BYTE_W-1:0]     o_data,
    output logic                  o_last,
    output logic                  o_accept
);

    localparam int NBYTES = bytes_per_word(DATA_WIDTH);
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [DATA_WIDTH-1:0] r_word;
    logic [BIDX_W-1:0]     r_bidx;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign o_accept  = r_valid && i_ready;
    assign o_last    = (r_bidx == BIDX_W'(NBYTES - 1));
    assign w_shifted = r_word >> (BYTE_W * r_bidx);
    assign o_data    = r_valid ? w_shifted[BYTE_W-1:0] : '0;
    assign o_valid   = r_valid;

    // NOTE: state registers use non-blocking assignments and clear asynchronously
    // on rst low, so every register reads its pre-edge value within the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word  <= '0;
            r_bidx  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_bidx  <= '0;
            r_valid <= 1'b1;
        end else if (o_accept) begin
            if (o_last) begin
                r_valid <= 1'b0;
            end else begin
                r_bidx <= r_bidx + BIDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_dump_reader.sv
// Reads a block of consecutive memory words after a start pulse and streams them
// out byte by byte to the debug UART transmitter. Never writes memory.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read_enable,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    dump_state_t           r_state;
    dump_state_t           w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_idx;
    logic [CNT_W-1:0]      w_idx_next;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_word_done;

    assign w_idx_next  = r_idx + CNT_W'(1);
    assign w_word_done = w_accept && w_last;
    assign w_load      = (r_state == ST_WAIT);

    assign mem_address      = r_addr;
    assign mem_read_enable  = (r_state == ST_READ);
    assign mem_write_enable = 1'b0;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (word_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: w_state_next = ST_WAIT;
            ST_WAIT: w_state_next = ST_SEND;
            ST_SEND: begin
                if (w_word_done) begin
                    w_state_next = (w_idx_next == r_count) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_addr tracks base+idx and is only moved when another READ follows,
    // so the last driven address is held between reads and after the dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_count <= word_count;
                r_idx   <= '0;
                if (word_count != '0) begin
                    r_addr <= base_addr;
                end
            end
            if (r_state == ST_SEND && w_word_done) begin
                r_idx <= w_idx_next;
                if (w_idx_next != r_count) begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    mem_dump_reader_word_byte_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_word  (mem_data),
        .i_ready (tx_ready),
        .o_valid (tx_valid),
        .o_data  (tx_data),
        .o_last  (w_last),
        .o_accept(w_accept)
    );

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench: a queue-based model of the expected address and byte
// streams, checked against the DUT every cycle, plus literal expectations.
module tb_mem_dump_reader;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [AW-1:0] mem_address;
    logic          mem_read_enable;
    logic          mem_write_enable;
    logic [DW-1:0] mem_data = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    mem_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .word_count      (word_count),
        .mem_address     (mem_address),
        .mem_read_enable (mem_read_enable),
        .mem_write_enable(mem_write_enable),
        .mem_data        (mem_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // Memory: one-cycle synchronous read
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_read_enable) mem_data <= mem[mem_address];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Model state and observations
    logic [7:0]    exp_bytes[$];
    logic [AW-1:0] exp_addrs[$];
    logic [7:0]    got_bytes[$];
    logic [AW-1:0] got_addrs[$];
    int cyc = 0;
    int done_cnt, read_cnt, valid_cnt;
    int first_read, first_valid, done_cyc;
    int last_k;
    logic mon_en = 1'b0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            check("write_enable", mem_write_enable, 0);
            if (mem_read_enable) begin
                read_cnt++;
                if (first_read < 0) first_read = cyc;
                got_addrs.push_back(mem_address);
                if (exp_addrs.size() == 0) fail_now("unexpected_read");
                else check("read_addr", mem_address, exp_addrs.pop_front());
            end
            if (prev_hold) check("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (tx_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                if (exp_bytes.size() == 0) fail_now("unexpected_tx_valid");
                else begin
                    check("tx_data", tx_data, exp_bytes[0]);
                    if (tx_ready) begin
                        got_bytes.push_back(tx_data);
                        void'(exp_bytes.pop_front());
                    end
                end
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_streams_drained", exp_bytes.size() + exp_addrs.size(), 0);
                check("busy_during_done", busy, 1);
            end
        end
    end

    // ready_mode 0: tx_ready tied high; 1: high one cycle in three.
    task automatic run_dump(input logic [AW-1:0] base, input int count,
                            input int ready_mode, input int spurious_at);
        logic [DW-1:0] w;
        int n;
        for (int i = 0; i < count; i++) begin
            w = mem[(int'(base) + i) % DEPTH];
            exp_addrs.push_back(AW'(int'(base) + i));
            for (int b = 0; b < NB; b++) exp_bytes.push_back(w[8*b +: 8]);
        end
        got_bytes.delete();
        got_addrs.delete();
        done_cnt = 0; read_cnt = 0; valid_cnt = 0;
        first_read = -1; first_valid = -1; done_cyc = -1;

        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = (AW+1)'(count);
        tx_ready = (ready_mode == 0);
        @(posedge clk); #1;
        last_k = cyc;
        start = 1'b0; base_addr = ~base; word_count = 7'd7;
        check("busy_after_start", busy, 1);
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (ready_mode == 1) tx_ready = (n % 3 == 0);
            if (n == spurious_at) begin
                start = 1'b1; base_addr = 5'd0; word_count = 7'd3;
            end else begin
                start = 1'b0;
            end
        end
        if (done_cnt == 0) fail_now("dump_timeout");
        start = 1'b0;
        tx_ready = 1'b0;
        @(negedge clk);
        check("single_done_pulse", done_cnt, 1);
        check("idle_after_done", busy, 0);
        check("read_cycles", read_cnt, count);
        check("model_drained", exp_bytes.size() + exp_addrs.size(), 0);
        if (count == 0) begin
            check("count0_done_cycle", done_cyc - last_k, 0);
            check("count0_no_valid", valid_cnt, 0);
        end else begin
            check("read_latency", first_read - last_k, 0);
            check("valid_latency", first_valid - last_k, 2);
            if (ready_mode == 0) check("dump_duration", done_cyc - last_k, count * (NB + 2));
        end
    endtask

    task automatic check_bytes(input string name, input logic [63:0] lit, input int nbytes);
        check({name, "_len"}, got_bytes.size(), nbytes);
        for (int i = 0; i < nbytes && i < got_bytes.size(); i++)
            check(name, got_bytes[i], lit[8*i +: 8]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lit;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h5A5A_0000 | i;
        mem[1]  = 32'h1234_5678;
        mem[2]  = 32'hABCD_EF01;
        mem[3]  = 32'h00C0_FFEE;
        mem[31] = 32'h0000_0001;
        mem[0]  = 32'h0000_0002;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_read_en", mem_read_enable, 0);
        check("rst_address", mem_address, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        mon_en = 1'b1;

        // Single word, ready tied high: 78 56 34 12
        run_dump(5'd1, 1, 0, 0);
        lit = 64'h0000_0000_1234_5678;
        check_bytes("word1_bytes", lit, 4);
        check("word1_duration_literal", done_cyc - last_k, 6);

        // Two words, back-pressure: 01 EF CD AB EE FF C0 00
        run_dump(5'd2, 2, 1, 0);
        lit = 64'h00C0_FFEE_ABCD_EF01;
        check_bytes("two_word_bytes", lit, 8);

        // Address wrap 31 -> 0
        run_dump(5'd31, 2, 0, 0);
        check("wrap_addr_count", got_addrs.size(), 2);
        if (got_addrs.size() == 2) begin
            check("wrap_addr0", got_addrs[0], 31);
            check("wrap_addr1", got_addrs[1], 0);
        end
        lit = 64'h0000_0002_0000_0001;
        check_bytes("wrap_bytes", lit, 8);

        // Zero words
        run_dump(5'd9, 0, 0, 0);

        // Start while busy must be ignored
        run_dump(5'd10, 2, 0, 4);

        // Reset in the middle of a stalled dump
        mon_en = 1'b0;
        mem[5] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 5'd5; word_count = 7'd3; tx_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_valid", tx_valid, 1);
        check("pre_reset_data", tx_data, 8'h0D);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_read_en", mem_read_enable, 0);
        check("mid_rst_address", mem_address, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_no_done", done, 0);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", busy, 0);
        check("post_rst_no_valid", tx_valid, 0);
        exp_bytes.delete();
        exp_addrs.delete();
        prev_hold = 1'b0;
        mon_en = 1'b1;

        // Recovery after abort
        run_dump(5'd1, 1, 0, 0);
        lit = 64'h0000_0000_1234_5678;
        check_bytes("recovery_bytes", lit, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
